// File: rtl/window_5x5_gen.sv
// window_5x5_gen
// Builds a 5x5 pixel neighbourhood from a raster-scan pixel stream. This is
// stage 0 of the order_25D pipeline. The previous four lines are kept in
// internal line buffers. For every pixel that completes a full window, all
// 25 window pixels are presented at once together with a one-cycle strobe.
//
// Ports
//   clock      : sole clock, all logic on the rising edge
//   rst_n      : asynchronous active-low reset
//   pix_valid  : pix_data and sof are valid this cycle
//   sof        : start of frame, only looked at when pix_valid is high
//   pix_data   : raster-order pixel, DSIZE bits
//   wd00..wd24 : window pixel wdRC with index r*5+c.
//                r=0 is the line four lines back, r=4 is the current line.
//                c=0 is four pixels back, c=4 is the current pixel.
//   win_valid  : one-cycle strobe; wd00..wd24 hold a complete window

module window_5x5_gen #(
    parameter int DSIZE  = 8,
    parameter int LINE_W = 640,
    parameter int CW     = 12
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             pix_valid,
    input  logic             sof,
    input  logic [DSIZE-1:0] pix_data,
    output logic [DSIZE-1:0] wd00, wd01, wd02, wd03, wd04,
    output logic [DSIZE-1:0] wd05, wd06, wd07, wd08, wd09,
    output logic [DSIZE-1:0] wd10, wd11, wd12, wd13, wd14,
    output logic [DSIZE-1:0] wd15, wd16, wd17, wd18, wd19,
    output logic [DSIZE-1:0] wd20, wd21, wd22, wd23, wd24,
    output logic             win_valid
);

    localparam int AW = (LINE_W > 1) ? $clog2(LINE_W) : 1;

    // col and row hold the position the next accepted pixel will take.
    // row saturates at 4, because beyond that line every line behaves the same.
    logic [CW-1:0]    col, pos_col, nxt_col;
    logic [2:0]       row, pos_row, nxt_row;
    logic [AW-1:0]    addr;
    logic [DSIZE-1:0] tap0, tap1, tap2, tap3;

    logic [DSIZE-1:0] lane [4][LINE_W];
    logic [DSIZE-1:0] win  [5][5];

    // A pixel with sof becomes (0,0) immediately. This way a mid-frame sof
    // restarts the count on that very pixel rather than on the following one.
    always_comb begin
        pos_col = col;
        pos_row = row;
        if (sof) begin
            pos_col = '0;
            pos_row = '0;
        end
        if (pos_col == CW'(LINE_W - 1)) begin
            nxt_col = '0;
            nxt_row = (pos_row == 3'd4) ? 3'd4 : pos_row + 3'd1;
        end else begin
            nxt_col = pos_col + CW'(1);
            nxt_row = pos_row;
        end
    end

    // The buffer reads are asynchronous. The taps therefore show the older
    // lines at this column before the write below overwrites them.
    assign addr = pos_col[AW-1:0];
    assign tap0 = lane[0][addr];
    assign tap1 = lane[1][addr];
    assign tap2 = lane[2][addr];
    assign tap3 = lane[3][addr];

    // Each lane pushes its old value down one lane, so lane k always holds
    // the line k+1 lines back. The contents survive reset, because stale
    // data is never flagged valid.
    always_ff @(posedge clock) begin
        if (pix_valid) begin
            lane[0][addr] <= pix_data;
            lane[1][addr] <= tap0;
            lane[2][addr] <= tap1;
            lane[3][addr] <= tap2;
        end
    end

    // Counters, window shift and strobe. The window only moves on accepted
    // pixels, so the wd outputs stay stable across idle cycles.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            col       <= '0;
            row       <= '0;
            win_valid <= 1'b0;
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 5; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else begin
            win_valid <= pix_valid && (pos_col >= CW'(4)) && (pos_row == 3'd4);
            if (pix_valid) begin
                col <= nxt_col;
                row <= nxt_row;
                for (int r = 0; r < 5; r++) begin
                    for (int c = 0; c < 4; c++) begin
                        win[r][c] <= win[r][c+1];
                    end
                end
                win[4][4] <= pix_data;
                win[3][4] <= tap0;
                win[2][4] <= tap1;
                win[1][4] <= tap2;
                win[0][4] <= tap3;
            end
        end
    end

    assign wd00 = win[0][0];
    assign wd01 = win[0][1];
    assign wd02 = win[0][2];
    assign wd03 = win[0][3];
    assign wd04 = win[0][4];
    assign wd05 = win[1][0];
    assign wd06 = win[1][1];
    assign wd07 = win[1][2];
    assign wd08 = win[1][3];
    assign wd09 = win[1][4];
    assign wd10 = win[2][0];
    assign wd11 = win[2][1];
    assign wd12 = win[2][2];
    assign wd13 = win[2][3];
    assign wd14 = win[2][4];
    assign wd15 = win[3][0];
    assign wd16 = win[3][1];
    assign wd17 = win[3][2];
    assign wd18 = win[3][3];
    assign wd19 = win[3][4];
    assign wd20 = win[4][0];
    assign wd21 = win[4][1];
    assign wd22 = win[4][2];
    assign wd23 = win[4][3];
    assign wd24 = win[4][4];

endmodule

// File: doc/window_5x5_gen.md
# window_5x5_gen

Streaming 5×5 neighbourhood generator feeding the 25-input ordering stage (order_25D pipeline, stage 0). It accepts a raster-scan pixel stream one pixel per valid cycle and buffers the previous four lines internally. For every pixel that completes a full 5×5 window, it presents all 25 window pixels in parallel with a one-cycle valid strobe. Its outputs wd00..wd24 connect one-to-one to the sorter inputs id00..id24.

## Interface
- DSIZE, 8, pixel width in bits
- LINE_W, 640, pixels per line; legal range 5..4096
- CW, 12, column counter width; must satisfy 2^CW ≥ LINE_W
- clock  in  1  sole clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- pix_valid  in  1  pix_data/sof valid this cycle
- sof  in  1  start of frame; sampled only when pix_valid=1
- pix_data  in  DSIZE  raster-order pixel
- wd00..wd24  out  DSIZE each  window pixel wdRC, index = r*5+c; r=0 is the line 4 lines back, r=4 the current line; c=0 is 4 pixels back, c=4 the current pixel
- win_valid  out  1  one-cycle strobe: wd00..wd24 hold a complete window

## Operation
- Counters:
  - col (CW bits) and row (3 bits, saturating at 4) track the position of the accepted pixel.
  - If pix_valid & sof, the pixel is position (0,0).
  - Otherwise, on pix_valid, col increments; at LINE_W-1, col wraps to 0 and row increments, saturating at 4.
- Line buffer:
  - Four lanes L0..L3, each LINE_W×DSIZE. Use register arrays or RAM with asynchronous read.
  - On an accepted pixel at column x: read L0[x]..L3[x]; these are the rows y-1..y-4 at column x.
  - Then write L0[x]=pix_data and Lk[x]=old L(k-1)[x] for k=1..3. Read-before-write within the same cycle is mandatory.
- Window array:
  - A 5×5 register grid. On an accepted pixel, every row shifts left by one (c ← c+1).
  - The new column c=4 is loaded with r4=pix_data, r3=L0[x], r2=L1[x], r1=L2[x], r0=L3[x].
- Validity:
  - win_valid is registered as 1 on the cycle after an accepted pixel with col≥4 and row≥4 (sof pixel counted as (0,0)); otherwise 0.
  - Windows never straddle a line boundary because col<4 is always invalid.
- No pix_valid: counters, window and line buffers hold; win_valid=0 next cycle.
- sof mid-line or mid-frame: counters restart immediately, so no window is emitted until the new frame's row 4, col 4. Line buffer contents are not cleared; stale data is never flagged valid.
- Reset (rst_n=0, any time, including mid-line):
  - col, row, win_valid and all wd outputs go to 0 immediately.
  - Line buffer contents are undefined after reset and are not cleared.
  - After release, the first accepted pixel is treated as (0,0) whether or not sof is asserted.

## Timing
- Latency: one clock from the accepted completing pixel to win_valid=1 with wd00..wd24 valid.
- wd outputs change only on accepted pixels, so they stay stable while pix_valid=0. Consumers must qualify them with win_valid.
- Throughput: one window per clock at 100% pix_valid. For LINE_W=W and H rows, each frame emits (W-4)·(H-4) strobes.
- Back-to-back frames: sof may directly follow the last pixel of the previous frame with no gap cycle.
- Reset values: all outputs 0.

## Test plan
- LINE_W=8, 8×8 frame, pixel value = row*16+col, continuous valid. Required response:
  - the first win_valid occurs the cycle after pixel 0x44, with wd00=0x00, wd12=0x22, wd24=0x44, wd04=0x04, wd20=0x40;
  - exactly 16 strobes for the frame;
  - the last strobe shows wd00=0x33 and wd24=0x77.
- Same frame with pix_valid toggling 1,0,0,1. Required response:
  - identical window contents and strobe count as the continuous case;
  - win_valid is never asserted two cycles after a pixel;
  - wd outputs hold during gaps.
- sof reasserted at pixel (2,5) of a frame. Required response: no strobe until the new frame's pixel (4,4) = 0x44, and that window matches the clean-frame expected contents.
- rst_n pulsed low mid-line at row 5. Required response:
  - all outputs read 0 during reset without a clock edge;
  - after release, the next 4 lines produce no strobe;
  - the first strobe is on the 5th line, column 4.
- Two back-to-back 8×8 frames with distinct data (frame B = value+0x80). Required response: 32 strobes total, and frame B's first window has wd00=0x80, wd24=0xC4.
